mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single unified RAM port between the pipeline's instruction-fetch requester and its data-memory requester.
- Produces the per-cycle ihit/dhit completions that drive the pipeline's stall, bubble and flush decisions.
- Data requests have priority because they come from the older, MEM-stage instruction. A streak limit guarantees that fetch cannot be starved.
- Also handles halt quiescing and a sticky RAM error.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.
- MAX_DSTREAK, 4, maximum consecutive data grants allowed while a fetch is pending.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  1  instruction fetch request.
- iaddr  in  ADDR_W  fetch address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- halt  in  1  pipeline halt.
- ihit  out  1  fetch completes this cycle.
- imemload  out  DATA_W  fetched word, valid when ihit=1.
- dhit  out  1  data access completes this cycle.
- dmemload  out  DATA_W  load data, valid when dhit=1.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ram_ready  in  1  RAM completes the current access this cycle.
- ram_error  in  1  RAM reports a fault.
- halted  out  1  arbiter quiesced.
- mem_error  out  1  sticky fault flag.

Behaviour:
- Reset:
  - Applied on any clock edge where RST=1, including mid-access. The in-flight access is abandoned and no hit is issued.
  - After reset: state=IDLE, streak=0, halted=0, mem_error=0.
  - All outputs are 0, including data outputs.
- States are IDLE, IGRANT, DGRANT, HALT, ERR.
- IDLE:
  - If dREN|dWEN is set and not (iREN and streak==MAX_DSTREAK), go to DGRANT.
  - Otherwise, if iREN is set, go to IGRANT.
  - Otherwise, if halt is set, go to HALT.
  - Otherwise, stay in IDLE.
  - Request sampling happens in IDLE only.
- DGRANT:
  - ramaddr=daddr and ramstore=dstore.
  - ramWEN=dWEN and ramREN=dREN&~dWEN. Write wins if both requests are set.
  - In the cycle where ram_ready=1: dhit=1, dmemload=ramload (reads), next state IDLE.
  - Streak update: if iREN=1, streak increments, saturating at MAX_DSTREAK. If iREN=0, streak clears.
- IGRANT:
  - ramREN=1 and ramaddr=iaddr.
  - In the cycle where ram_ready=1: ihit=1, imemload=ramload, streak clears, next state IDLE.
- Timing:
  - Hits are combinational on ram_ready within the grant state.
  - ram* outputs are decoded from state and the current request inputs.
  - Minimum access is 2 cycles: 1 IDLE plus 1 grant with ram_ready.
- Requester rules:
  - A requester holds its request and address stable until its hit.
  - If a request drops mid-grant, the access still completes and the hit still pulses.
- Halt:
  - halt never aborts a grant.
  - From IDLE with no pending request, the arbiter enters HALT.
  - In HALT: halted=1, no ram strobes and no hits, regardless of requests. Only RST exits.
- Error:
  - ram_error=1 in a grant state moves to ERR. No hit is issued that cycle.
  - In ERR: mem_error=1, no strobes or hits. Only RST exits.
  - ram_error in IDLE or HALT is ignored.
- Simultaneous ram_ready and ram_error: error wins.
- Outside a grant state: ihit=dhit=0 and ramREN=ramWEN=0.

Decomposition:
- The shared package cpu_types_pkg holds:
  - the arbiter state enum arb_state_t (IDLE, IGRANT, DGRANT, HALT, ERR);
  - the word_t typedef;
  - the MAX_DSTREAK default constant.
- One natural sub-module is streak_counter: a saturating counter with inc, clr and sat outputs, width $clog2(MAX_DSTREAK+1).

Test Plan:
- Fetch only:
  - Stimulus: iREN=1, iaddr=0x40; RAM returns 0x8C010004 with ram_ready 2 cycles after grant.
  - Response: ihit high exactly 1 cycle with imemload=0x8C010004. No dhit.
- Contention:
  - Stimulus: iREN=1 and dREN=1, daddr=0x100, together in IDLE.
  - Response: DGRANT first and dhit first. The next grant is IGRANT and ihit follows.
- Starvation guard:
  - Stimulus: dWEN held continuously, iREN held, MAX_DSTREAK=4, ram_ready=1 each grant.
  - Response: 4 writes, then 1 fetch, repeating. streak returns to 0 after each ihit.
- Write plus read together:
  - Stimulus: dREN=dWEN=1, daddr=0x200, dstore=0xDEADBEEF.
  - Response: ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- Halt during access:
  - Stimulus: halt rises mid-DGRANT; ram_ready arrives 3 cycles later.
  - Response: dhit pulses, then IDLE, then HALT with halted=1. Later iREN produces no ramREN.
- Fault and reset:
  - Stimulus: ram_error together with ram_ready in IGRANT.
  - Response: no ihit; mem_error=1 persists.
  - Then RST=1 for 1 cycle: all outputs return to 0 and the next iREN is served normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: state encoding, word type and the default
// cap on back-to-back data grants while a fetch is waiting.
package cpu_types_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IGRANT = 3'd1,
        DGRANT = 3'd2,
        HALT   = 3'd3,
        ERR    = 3'd4
    } arb_state_t;

    typedef logic [31:0] word_t;

    localparam int DEF_MAX_DSTREAK = 4;

endpackage

// File: rtl/streak_counter.sv
// Saturating count of consecutive data grants taken while a fetch was pending.
// One-cycle update; clear has priority over increment, increment holds at MAX.
module streak_counter #(
    parameter  int MAX = 4,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sat = (r_cnt == W'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between fetch and data requesters; data wins unless fetch has waited MAX_DSTREAK grants.
// Hits are combinational on ram_ready inside a grant (min 2-cycle access); HALT and ERR are exited only by RST.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    input  logic              halt,
    output logic              ihit,
    output logic [DATA_W-1:0] imemload,
    output logic              dhit,
    output logic [DATA_W-1:0] dmemload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    input  logic              ram_error,
    output logic              halted,
    output logic              mem_error
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       w_inc;
    logic       w_clr;
    logic       w_sat;

    streak_counter #(.MAX(MAX_DSTREAK)) u_streak (
        .i_clk (CLK),
        .i_rst (RST),
        .i_inc (w_inc),
        .i_clr (w_clr),
        .o_sat (w_sat)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_inc     = 1'b0;
        w_clr     = 1'b0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        imemload  = '0;
        dmemload  = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        halted    = 1'b0;
        mem_error = 1'b0;

        case (r_state)
            IDLE: begin
                // A fetch that has watched MAX_DSTREAK data grants go by takes the next slot.
                if ((dREN || dWEN) && !(iREN && w_sat)) begin
                    w_next = DGRANT;
                end else if (iREN) begin
                    w_next = IGRANT;
                end else if (halt) begin
                    w_next = HALT;
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                if (ram_error) begin
                    w_next = ERR;
                end else if (ram_ready) begin
                    dhit     = 1'b1;
                    dmemload = ramload;
                    w_inc    = iREN;
                    w_clr    = !iREN;
                    w_next   = IDLE;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (ram_error) begin
                    w_next = ERR;
                end else if (ram_ready) begin
                    ihit     = 1'b1;
                    imemload = ramload;
                    w_clr    = 1'b1;
                    w_next   = IDLE;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            ERR: begin
                mem_error = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: expected hits are queued as stimulus is issued; a negedge monitor pops and compares each hit.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, halt = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
    logic        ihit, dhit, ramREN, ramWEN, halted, mem_error;
    logic [31:0] imemload, dmemload, ramaddr, ramstore;
    logic [31:0] ramload = '0;
    logic        ram_ready = 1'b0, ram_error = 1'b0;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        bit          wen;
        logic [31:0] store;
        bit          chk_load;
        logic [31:0] load;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   lat = 0;
    int   rcnt = 0;
    bit   err_mode = 1'b0;

    mem_arbiter dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .halt(halt), .ihit(ihit), .imemload(imemload),
        .dhit(dhit), .dmemload(dmemload), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready),
        .ram_error(ram_error), .halted(halted), .mem_error(mem_error)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h8C010004;
            32'h100: return 32'h12345678;
            32'h200: return 32'hCAFEF00D;
            default: return 32'hA5A50000 | {16'h0, a[15:0]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ihit"}, {31'h0, ihit}, 0);
        chk({tag, ".dhit"}, {31'h0, dhit}, 0);
        chk({tag, ".ramREN"}, {31'h0, ramREN}, 0);
        chk({tag, ".ramWEN"}, {31'h0, ramWEN}, 0);
        chk({tag, ".ramaddr"}, ramaddr, 0);
        chk({tag, ".ramstore"}, ramstore, 0);
        chk({tag, ".imemload"}, imemload, 0);
        chk({tag, ".dmemload"}, dmemload, 0);
        chk({tag, ".halted"}, {31'h0, halted}, 0);
        chk({tag, ".mem_error"}, {31'h0, mem_error}, 0);
    endtask

    task automatic push(input bit is_d, input logic [31:0] addr, input bit wen,
                        input logic [31:0] store, input bit chk_load, input logic [31:0] load);
        exp_t e;
        e.is_d = is_d; e.addr = addr; e.wen = wen; e.store = store;
        e.chk_load = chk_load; e.load = load;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns at posedge+1 once at most n expected hits remain outstanding.
    task automatic wait_q(input int n, input int budget, input string tag);
        int k = 0;
        while (exp_q.size() > n && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (exp_q.size() > n) begin
            n_err++;
            $display("FAIL %s timeout: %0d hits pending, expected %0d", tag, exp_q.size(), n);
            while (exp_q.size() > n) void'(exp_q.pop_front());
        end
    endtask

    // RAM model: ram_ready (and ram_error in err_mode) on grant cycle index lat.
    always @(posedge CLK) begin
        #2;
        if (ramREN || ramWEN) begin
            ram_ready = (rcnt == lat);
            ram_error = err_mode && (rcnt == lat);
            ramload   = (rcnt == lat) ? ram_word(ramaddr) : 32'h0;
            rcnt++;
        end else begin
            ram_ready = 1'b0;
            ram_error = 1'b0;
            ramload   = 32'h0;
            rcnt      = 0;
        end
    end

    always @(negedge CLK) begin
        if (ihit || dhit) begin
            if (ihit && dhit) chk("both_hits", 1, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_hit", {30'h0, ihit, dhit}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("hit_kind_dhit", {31'h0, dhit}, {31'h0, mon_e.is_d});
                chk("hit_ramaddr", ramaddr, mon_e.addr);
                if (mon_e.is_d) begin
                    chk("hit_ramWEN", {31'h0, ramWEN}, {31'h0, mon_e.wen});
                    if (mon_e.wen) begin
                        chk("hit_ramstore", ramstore, mon_e.store);
                        chk("hit_ramREN_on_write", {31'h0, ramREN}, 0);
                    end
                end
                if (mon_e.chk_load)
                    chk(mon_e.is_d ? "dmemload" : "imemload",
                        mon_e.is_d ? dmemload : imemload, mon_e.load);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        @(negedge CLK);
        chk_zero("reset");
        tick();
        RST = 1'b0;

        // Fetch only, ready on the third grant cycle
        lat = 2;
        push(0, 32'h40, 0, 0, 1, 32'h8C010004);
        iREN = 1'b1; iaddr = 32'h40;
        wait_q(0, 20, "fetch_only");
        iREN = 1'b0;

        // Contention: data first, then fetch
        lat = 1;
        push(1, 32'h100, 0, 0, 1, 32'h12345678);
        push(0, 32'h40, 0, 0, 1, 32'h8C010004);
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h100;
        wait_q(1, 20, "contention_d");
        dREN = 1'b0;
        wait_q(0, 20, "contention_i");
        iREN = 1'b0;

        // Starvation guard: 4 writes then 1 fetch, twice
        lat = 0;
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 4; w++) push(1, 32'h300, 1, 32'h11110000, 0, 0);
            push(0, 32'h44, 0, 0, 1, 32'hA5A50044);
        end
        dWEN = 1'b1; daddr = 32'h300; dstore = 32'h11110000;
        iREN = 1'b1; iaddr = 32'h44;
        wait_q(0, 60, "starvation");
        dWEN = 1'b0; iREN = 1'b0;

        // Read and write together: the write wins
        lat = 1;
        push(1, 32'h200, 1, 32'hDEADBEEF, 0, 0);
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
        wait_q(0, 20, "rw_together");
        dREN = 1'b0; dWEN = 1'b0;

        // Halt raised mid-grant does not abort it
        lat = 3;
        push(1, 32'h100, 0, 0, 1, 32'h12345678);
        dREN = 1'b1; daddr = 32'h100;
        tick();
        halt = 1'b1;
        wait_q(0, 20, "halt_dgrant");
        dREN = 1'b0;
        @(negedge CLK);
        chk("halted_in_idle", {31'h0, halted}, 0);
        tick();
        iREN = 1'b1; iaddr = 32'h40;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("halted", {31'h0, halted}, 1);
            chk("halt_ramREN", {31'h0, ramREN}, 0);
        end

        // Fault with simultaneous ready: error wins, sticky until reset
        err_mode = 1'b1; lat = 1;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; halt = 1'b0;
        @(negedge CLK);
        chk_zero("halt_reset");
        repeat (4) tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("mem_error", {31'h0, mem_error}, 1);
            chk("err_ramREN", {31'h0, ramREN}, 0);
        end
        err_mode = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk_zero("err_reset");
        push(0, 32'h40, 0, 0, 1, 32'h8C010004);
        wait_q(0, 20, "fetch_after_reset");
        iREN = 1'b0;

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
